// File: rtl/midi_merge_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : midi_merge_arbiter
// Purpose : Grants one of four idle-high serial MIDI inputs exclusive use of
//           the merged outputs for a whole frame plus an inter-byte gap.
// Revision: 1.0
// ============================================================================
module midi_merge_arbiter #(
    parameter int BIT_TICKS = 32,
    parameter int GAP_BITS  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] midi_in,
    input  logic [3:0] midi_dst,
    output logic [3:0] midi_out,
    output logic [3:0] grant,
    output logic       busy,
    output logic [7:0] lost_cnt
);

    localparam int FRAME_LEN = 10 * BIT_TICKS;
    localparam int GAP_LEN   = GAP_BITS * BIT_TICKS;
    localparam int TIMER_MAX = (FRAME_LEN > GAP_LEN) ? FRAME_LEN : GAP_LEN;
    localparam int TW        = $clog2(TIMER_MAX + 1);
    localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    logic [3:0]    sync1_q, sync2_q, prev_q;
    logic [1:0]    settle_q;
    logic [3:0]    fall;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic          busy_q, busy_d;
    logic          lost_q, lost_d;
    logic [3:0]    dst_q, dst_d;
    logic [3:0]    out_q, out_d;
    logic [7:0]    lost_cnt_q, lost_cnt_d;

    logic          win_found;
    logic [1:0]    win_idx;
    logic [3:0]    win_mask;
    logic [3:0]    owner_mask;
    logic          others_fall;

    // Edge detection stays masked until the previous-sample register holds
    // real pin data, so an input held low through reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 4'hF;
            sync2_q  <= 4'hF;
            prev_q   <= 4'hF;
            settle_q <= 2'd0;
        end else begin
            sync1_q <= midi_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    assign fall = (settle_q == 2'd3) ? (prev_q & ~sync2_q) : 4'h0;

    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!win_found && fall[rr_ptr_q + 2'(k)]) begin
                win_found = 1'b1;
                win_idx   = rr_ptr_q + 2'(k);
            end
        end
    end

    assign win_mask    = 4'b0001 << win_idx;
    assign owner_mask  = 4'b0001 << owner_q;
    assign others_fall = |(fall & ~owner_mask);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        busy_d     = busy_q;
        lost_d     = lost_q;
        dst_d      = dst_q;
        lost_cnt_d = lost_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_FRAME;
                    timer_d = '0;
                    owner_d = win_idx;
                    busy_d  = 1'b1;
                    dst_d   = midi_dst;
                    lost_d  = |(fall & ~win_mask);
                end
            end
            ST_FRAME: begin
                if (others_fall) begin
                    lost_d = 1'b1;
                end
                if (timer_q == FRAME_LAST) begin
                    state_d = ST_GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_GAP: begin
                if (fall[owner_q]) begin
                    state_d = ST_FRAME;
                    timer_d = '0;
                    if (others_fall) begin
                        lost_d = 1'b1;
                    end
                end else if (timer_q == GAP_LAST) begin
                    // A non-owner edge landing on the release cycle is dropped.
                    state_d  = ST_IDLE;
                    timer_d  = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = owner_q + 2'd1;
                    lost_d   = 1'b0;
                    if (lost_q && (lost_cnt_q != 8'hFF)) begin
                        lost_cnt_d = lost_cnt_q + 8'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (others_fall) begin
                        lost_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Next-state ownership drives the output mux so the start bit keeps the
    // same three-clock latency as every later bit.
    always_comb begin
        out_d = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (busy_d && dst_d[i]) begin
                out_d[i] = sync2_q[owner_d];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            owner_q    <= 2'd0;
            rr_ptr_q   <= 2'd0;
            busy_q     <= 1'b0;
            lost_q     <= 1'b0;
            dst_q      <= 4'h0;
            out_q      <= 4'hF;
            lost_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            busy_q     <= busy_d;
            lost_q     <= lost_d;
            dst_q      <= dst_d;
            out_q      <= out_d;
            lost_cnt_q <= lost_cnt_d;
        end
    end

    assign midi_out = out_q;
    assign busy     = busy_q;
    assign grant    = busy_q ? owner_mask : 4'h0;
    assign lost_cnt = lost_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_merge_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_midi_merge_arbiter
// Purpose : Randomized and directed stimulus for midi_merge_arbiter, checked
//           every cycle against a frame/deadline-level reference model.
// Revision: 1.0
// ============================================================================
module tb_midi_merge_arbiter;

    localparam int BT        = 4;
    localparam int GB        = 2;
    localparam int FRAME_CYC = 10 * BT;
    localparam int GAP_CYC   = GB * BT;
    localparam int MAXC      = 16384;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] midi_in;
    logic [3:0] midi_dst;
    logic [3:0] midi_out;
    logic [3:0] grant;
    logic       busy;
    logic [7:0] lost_cnt;

    midi_merge_arbiter #(.BIT_TICKS(BT), .GAP_BITS(GB)) dut (
        .clk      (clk),
        .rst      (rst),
        .midi_in  (midi_in),
        .midi_dst (midi_dst),
        .midi_out (midi_out),
        .grant    (grant),
        .busy     (busy),
        .lost_cnt (lost_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [3:0] ph [0:MAXC-1];
    logic [3:0] dh [0:MAXC-1];

    bit [7:0] txq [4][$];
    bit [9:0] tx_sh   [4];
    int       tx_bits [4];
    int       tx_tick [4];
    int       tx_wait [4];
    int       gap_cfg  = 2;
    bit       rand_gap = 1'b0;
    bit [3:0] hold_low = 4'h0;
    bit [3:0] dst_cur  = 4'h0;

    int       m_owner;
    int       m_fs;
    int       m_rr;
    bit       m_lost;
    int       m_cnt;
    bit [3:0] m_dst;
    logic [3:0] e_grant;
    logic       e_busy;
    logic [3:0] e_out;

    logic [3:0] seen_grant;
    logic [3:0] low_seen;
    int         n_own;
    int         busy_cyc;
    logic       busy_prev;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Per-input UART transmitters: start bit, 8 data bits LSB first, stop bit.
    task automatic tx_cycle(output logic [3:0] p);
        bit [7:0] b;
        for (int i = 0; i < 4; i++) begin
            if (tx_bits[i] == 0 && tx_wait[i] == 0 && txq[i].size() > 0) begin
                b          = txq[i].pop_front();
                tx_sh[i]   = {1'b1, b, 1'b0};
                tx_bits[i] = 10;
                tx_tick[i] = 0;
            end
            if (tx_bits[i] > 0) begin
                p[i] = tx_sh[i][0];
                tx_tick[i]++;
                if (tx_tick[i] == BT) begin
                    tx_tick[i] = 0;
                    tx_sh[i]   = tx_sh[i] >> 1;
                    tx_bits[i]--;
                    if (tx_bits[i] == 0) begin
                        tx_wait[i] = rand_gap ? int'($urandom_range(0, 12)) : gap_cfg;
                    end
                end
            end else begin
                p[i] = 1'b1;
                if (tx_wait[i] > 0) tx_wait[i]--;
            end
        end
        p = p & ~hold_low;
    endtask

    task automatic drive_cycle();
        logic [3:0] p;
        tx_cycle(p);
        ph[cyc]  = p;
        dh[cyc]  = dst_cur;
        midi_in  = p;
        midi_dst = dst_cur;
    endtask

    // Reference: pin value driven in cycle c reaches the synchronised sample in
    // cycle c+2; a start edge is seen in cycle c when pins went 1 -> 0 between
    // cycles c-3 and c-2. Ownership is tracked as a frame-start deadline.
    task automatic model_step(input int c);
        logic [3:0] f;
        logic [3:0] s2;
        logic [3:0] others;
        bit         found;
        f  = (c >= 3) ? (ph[c-3] & ~ph[c-2]) : 4'h0;
        s2 = (c >= 2) ? ph[c-2] : 4'hF;
        if (m_owner < 0) begin
            if (f != 4'h0) begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && f[(m_rr + k) % 4]) begin
                        found   = 1'b1;
                        m_owner = (m_rr + k) % 4;
                    end
                end
                m_fs   = c + 1;
                m_dst  = dh[c];
                m_lost = ($countones(f) > 1);
            end
        end else begin
            others = f & ~(4'b0001 << m_owner);
            if (c < m_fs + FRAME_CYC) begin
                m_lost = m_lost | (others != 4'h0);
            end else if (f[m_owner]) begin
                m_fs   = c + 1;
                m_lost = m_lost | (others != 4'h0);
            end else if (c == m_fs + FRAME_CYC + GAP_CYC - 1) begin
                if (m_lost && m_cnt < 255) m_cnt++;
                m_lost  = 1'b0;
                m_rr    = (m_owner + 1) % 4;
                m_owner = -1;
            end else begin
                m_lost = m_lost | (others != 4'h0);
            end
        end
        e_busy  = (m_owner >= 0);
        e_grant = e_busy ? (4'b0001 << m_owner) : 4'h0;
        for (int i = 0; i < 4; i++) begin
            e_out[i] = (e_busy && m_dst[i]) ? s2[m_owner] : 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step(cyc);
        check_eq("grant", grant, e_grant);
        check_eq("busy", busy, e_busy);
        check_eq("midi_out", midi_out, e_out);
        check_eq("lost_cnt", lost_cnt, m_cnt);
        seen_grant = seen_grant | grant;
        low_seen   = low_seen | ~midi_out;
        if (busy && !busy_prev) n_own++;
        if (busy) busy_cyc++;
        busy_prev = busy;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL history_overflow: observed %0d expected below %0d", cyc, MAXC);
            n_bad++;
            $fatal(1, "history overflow");
        end
        drive_cycle();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_obs();
        seen_grant = 4'h0;
        low_seen   = 4'h0;
        n_own      = 0;
        busy_cyc   = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        check_eq("rst_grant", grant, 4'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_midi_out", midi_out, 4'hF);
        check_eq("rst_lost_cnt", lost_cnt, 8'h00);
        for (int i = 0; i < 4; i++) begin
            txq[i].delete();
            tx_bits[i] = 0;
            tx_tick[i] = 0;
            tx_wait[i] = 0;
        end
        midi_in  = 4'hF & ~hold_low;
        midi_dst = dst_cur;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        m_owner   = -1;
        m_fs      = 0;
        m_rr      = 0;
        m_lost    = 1'b0;
        m_cnt     = 0;
        m_dst     = 4'h0;
        busy_prev = 1'b0;
        cyc       = 0;
        drive_cycle();
    endtask

    initial begin
        rst      = 1'b0;
        midi_in  = 4'hF;
        midi_dst = 4'h0;
        clear_obs();
        #1;
        apply_reset();

        // Idle after reset: nothing may move.
        run(100);
        check_eq("idle_grant_seen", seen_grant, 4'h0);
        check_eq("idle_ownerships", n_own, 0);

        // Single byte on input 2 routed to outputs 0 and 2.
        clear_obs();
        dst_cur = 4'b0101;
        txq[2].push_back(8'h90);
        run(70);
        check_eq("s1_grant_seen", seen_grant, 4'b0100);
        check_eq("s1_busy_cycles", busy_cyc, FRAME_CYC + GAP_CYC);
        check_eq("s1_low_outputs", low_seen, 4'b0101);

        // Running-status burst on input 1 with a 2-cycle gap after each stop.
        clear_obs();
        dst_cur = 4'b1010;
        txq[1].push_back(8'h90);
        txq[1].push_back(8'h3C);
        txq[1].push_back(8'h64);
        run(180);
        check_eq("s2_grant_seen", seen_grant, 4'b0010);
        check_eq("s2_ownerships", n_own, 1);

        // Simultaneous starts on inputs 0 and 3 from a fresh round-robin pointer.
        apply_reset();
        clear_obs();
        dst_cur = 4'b1111;
        txq[0].push_back(8'hA7);
        txq[3].push_back(8'h5E);
        run(70);
        check_eq("s3a_grant_seen", seen_grant, 4'b0001);
        check_eq("s3a_lost_cnt", lost_cnt, 8'd1);
        clear_obs();
        txq[0].push_back(8'h12);
        txq[3].push_back(8'hEF);
        run(70);
        check_eq("s3b_grant_seen", seen_grant, 4'b1000);
        check_eq("s3b_lost_cnt", lost_cnt, 8'd2);

        // Destination change in mid-frame applies from the next ownership.
        clear_obs();
        dst_cur = 4'b0001;
        txq[1].push_back(8'h55);
        run(13);
        dst_cur = 4'b1000;
        run(60);
        check_eq("s4a_low_outputs", low_seen, 4'b0001);
        clear_obs();
        txq[1].push_back(8'hA5);
        run(70);
        check_eq("s4b_low_outputs", low_seen, 4'b1000);

        // Random traffic with random inter-byte gaps and destination masks.
        rand_gap = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (txq[i].size() == 0 && tx_bits[i] == 0 && $urandom_range(0, 119) == 0) begin
                    txq[i].push_back(8'($urandom));
                end
            end
            if ($urandom_range(0, 99) == 0) dst_cur = 4'($urandom);
            step();
        end
        rand_gap = 1'b0;
        run(80);

        // Reset in mid-frame with the source pin left low afterwards.
        clear_obs();
        dst_cur = 4'b0001;
        txq[0].push_back(8'h00);
        run(19);
        check_eq("s5_busy_before_rst", busy, 1'b1);
        hold_low = 4'b0001;
        apply_reset();
        clear_obs();
        run(40);
        check_eq("s5_no_grant_held_low", n_own, 0);
        hold_low = 4'b0000;
        run(10);
        txq[0].push_back(8'h42);
        run(70);
        check_eq("s5_grant_after_new_edge", seen_grant, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
